alu_req_arbiter: RTL

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared 16-bit ALU: grants one request, runs it, holds the response.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins); undefined gives round-robin.
module alu_req_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_op;
    logic        r_idx;
    logic        r_rsp_id;
    logic [15:0] r_rsp_result;
    logic [3:0]  r_rsp_flags;
    logic        w_any;
    logic        w_pick;
    logic        w_accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_pick = ~req0_valid;
`else
    logic r_last;

    // On contention, grant whichever requester did not win last time.
    assign w_pick = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;
`endif

    assign w_any    = req0_valid | req1_valid;
    // Gating with rst_n keeps the readies low while reset is held.
    assign w_accept = (r_state == S_IDLE) && w_any && rst_n;

    assign req0_ready = w_accept && !w_pick;
    assign req1_ready = w_accept && w_pick;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)     w_state_next = S_EXEC;
            S_EXEC:                 w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= 16'h0000;
            r_b          <= 16'h0000;
            r_op         <= 4'h0;
            r_idx        <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_flags  <= 4'h0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= w_pick ? req1_a  : req0_a;
                r_b   <= w_pick ? req1_b  : req0_b;
                r_op  <= w_pick ? req1_op : req0_op;
                r_idx <= w_pick;
            end
            if (r_state == S_EXEC) begin
                r_rsp_id     <= r_idx;
                r_rsp_result <= alu_result;
                r_rsp_flags  <= alu_flags;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_pick;
        end
    end
`endif

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule
